// File: rtl/tube_pkg.sv
// rtl/tube_pkg.sv - shared game state encoding, screen geometry and coordinate type
// Purpose: common definitions for the tube game judge and its helpers.
// Contents: game_state_t (IDLE/PLAY/HIT/OVER), SCREEN_W/SCREEN_H, coord_t.
package tube_pkg;

  typedef logic [9:0] coord_t;

  localparam int SCREEN_W = 850;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } game_state_t;

endpackage

// File: rtl/bcd_sat_adder3.sv
// rtl/bcd_sat_adder3.sv - 3-digit BCD plus small binary increment, saturating at 999
// Purpose: adds a 0..15 binary increment to a 3-digit BCD value.
// Ports:
//   bcd_in   in  12  current value, 3 BCD digits
//   inc      in  4   binary increment (0..15)
//   bcd_out  out 12  bcd_in + inc, clamped to 999
module bcd_sat_adder3 (
  input  logic [11:0] bcd_in,
  input  logic [3:0]  inc,
  output logic [11:0] bcd_out
);

  logic [4:0] s0, s1, s2;
  logic [4:0] d0, d1;
  logic [1:0] c0;
  logic       c1;

  always_comb begin
    // units digit can reach 9 + 15 = 24, so it may carry two tens
    s0 = {1'b0, bcd_in[3:0]} + {1'b0, inc};
    if (s0 >= 5'd20) begin
      d0 = s0 - 5'd20;
      c0 = 2'd2;
    end else if (s0 >= 5'd10) begin
      d0 = s0 - 5'd10;
      c0 = 2'd1;
    end else begin
      d0 = s0;
      c0 = 2'd0;
    end

    s1 = {1'b0, bcd_in[7:4]} + {3'b000, c0};
    if (s1 >= 5'd10) begin
      d1 = s1 - 5'd10;
      c1 = 1'b1;
    end else begin
      d1 = s1;
      c1 = 1'b0;
    end

    s2 = {1'b0, bcd_in[11:8]} + {4'b0000, c1};
    if (s2 >= 5'd10) begin
      bcd_out = 12'h999;
    end else begin
      bcd_out = {s2[3:0], d1[3:0], d0[3:0]};
    end
  end

endmodule

// File: rtl/tube_hit_judge.sv
// rtl/tube_hit_judge.sv - bird/tube collision, pass scoring and game state machine
// Purpose: judges one game frame per tick from tube rectangles and bird position.
// Optional feature macro: TUBE_HISCORE_EN (builds the best-score register).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   tick                one-cycle frame strobe; judging only on tick
//   start               player start/restart level
//   bird_h, bird_v      bird box left x / top y
//   rect_h/v/w/ht       packed per-rectangle left x, top y, width, height (10 bits each)
//   game_state          0 IDLE, 1 PLAY, 2 HIT, 3 OVER
//   collide             one-cycle pulse on PLAY->HIT
//   freeze              high in HIT and OVER
//   score_bcd           current score, 3 BCD digits
//   hiscore_bcd         best score since reset (0 when TUBE_HISCORE_EN undefined)
module tube_hit_judge
  import tube_pkg::*;
#(
  parameter int                N_RECT     = 8,
  parameter logic [N_RECT-1:0] SCORE_MASK = N_RECT'(8'b0101_0101),
  parameter int                BIRD_W     = 34,
  parameter int                BIRD_H     = 24,
  parameter int                HIT_FRAMES = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  start,
  input  logic [9:0]            bird_h,
  input  logic [9:0]            bird_v,
  input  logic [10*N_RECT-1:0]  rect_h,
  input  logic [10*N_RECT-1:0]  rect_v,
  input  logic [10*N_RECT-1:0]  rect_w,
  input  logic [10*N_RECT-1:0]  rect_ht,
  output logic [1:0]            game_state,
  output logic                  collide,
  output logic                  freeze,
  output logic [11:0]           score_bcd,
  output logic [11:0]           hiscore_bcd
);

  localparam int              CNT_W    = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;
  localparam logic [CNT_W-1:0] HIT_LAST = CNT_W'(HIT_FRAMES - 1);

  game_state_t state, state_next;

  // Stage 1: geometry tests, all in 11 bits so sums never wrap
  logic [N_RECT-1:0] overlap_now, ahead_now;
  logic [10:0]       bird_r, bird_b;
  logic              floor_now;
  coord_t            rh, rv, rw, rt;

  assign bird_r    = {1'b0, bird_h} + 11'(BIRD_W);
  assign bird_b    = {1'b0, bird_v} + 11'(BIRD_H);
  assign floor_now = bird_b > 11'(SCREEN_H);

  always_comb begin
    overlap_now = '0;
    ahead_now   = '0;
    rh = '0; rv = '0; rw = '0; rt = '0;
    for (int i = 0; i < N_RECT; i++) begin
      rh = rect_h[10*i +: 10];
      rv = rect_v[10*i +: 10];
      rw = rect_w[10*i +: 10];
      rt = rect_ht[10*i +: 10];
      ahead_now[i]   = ({1'b0, rh} + {1'b0, rw}) > {1'b0, bird_h};
      // an empty rectangle would otherwise match when it sits inside the bird box
      overlap_now[i] = (rw != '0) && (rt != '0)
                    && ({1'b0, bird_h} < {1'b0, rh} + {1'b0, rw})
                    && ({1'b0, rh} < bird_r)
                    && ({1'b0, bird_v} < {1'b0, rv} + {1'b0, rt})
                    && ({1'b0, rv} < bird_b);
    end
  end

  logic              s1_valid, hit_q;
  logic [N_RECT-1:0] pass_q, ahead_hist;
  logic              go_hit, go_over, do_start, add_pass;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      hit_q      <= 1'b0;
      pass_q     <= '0;
      ahead_hist <= '0;
    end else begin
      s1_valid <= tick;
      if (tick) begin
        hit_q      <= (|overlap_now) | floor_now;
        // wrap only raises ahead, so a falling edge is a genuine pass
        pass_q     <= SCORE_MASK & ahead_hist & ~ahead_now;
        ahead_hist <= ahead_now;
      end
      // a fresh game starts with no history and drops any in-flight judgement
      if (do_start) begin
        s1_valid   <= 1'b0;
        ahead_hist <= '0;
      end
    end
  end

  // Stage 2: pass count feeds the saturating BCD score adder (N_RECT <= 15)
  logic [3:0]  pass_cnt;
  logic [11:0] score_sum;

  always_comb begin
    pass_cnt = 4'd0;
    for (int i = 0; i < N_RECT; i++) begin
      pass_cnt = pass_cnt + {3'b000, pass_q[i]};
    end
  end

  bcd_sat_adder3 u_score_add (
    .bcd_in  (score_bcd),
    .inc     (pass_cnt),
    .bcd_out (score_sum)
  );

  logic [CNT_W-1:0] hit_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    go_hit     = 1'b0;
    go_over    = 1'b0;
    do_start   = 1'b0;
    add_pass   = 1'b0;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_next = ST_PLAY;
          do_start   = 1'b1;
        end
      end
      ST_PLAY: begin
        if (s1_valid) begin
          if (hit_q) begin
            state_next = ST_HIT;
            go_hit     = 1'b1;
          end else begin
            add_pass = 1'b1;
          end
        end
      end
      ST_HIT: begin
        if (s1_valid && (hit_cnt == HIT_LAST)) begin
          state_next = ST_OVER;
          go_over    = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      score_bcd <= '0;
      hit_cnt   <= '0;
      collide   <= 1'b0;
    end else begin
      collide <= go_hit;
      if (do_start)      score_bcd <= '0;
      else if (add_pass) score_bcd <= score_sum;
      if (go_hit)                          hit_cnt <= '0;
      else if (state == ST_HIT && s1_valid) hit_cnt <= hit_cnt + 1'b1;
    end
  end

`ifdef TUBE_HISCORE_EN
  logic [11:0] hiscore_q;
  // BCD digits are ordered by weight, so a plain unsigned compare is valid
  always_ff @(posedge clk) begin
    if (rst)                                  hiscore_q <= '0;
    else if (go_over && score_bcd > hiscore_q) hiscore_q <= score_bcd;
  end
  assign hiscore_bcd = hiscore_q;
`else
  assign hiscore_bcd = 12'h000;
`endif

  assign game_state = state;
  assign freeze     = (state == ST_HIT) || (state == ST_OVER);

endmodule

// File: tb/tb_tube_hit_judge.sv
// tb/tb_tube_hit_judge.sv - self-checking bench for tube_hit_judge
module tb_tube_hit_judge;

  localparam int N  = 8;
  localparam int BW = 34;
  localparam int BH = 24;
  localparam int HF = 30;
  localparam logic [7:0] MASK = 8'b0101_0101;

  logic        clk = 1'b0;
  logic        rst, tick, start;
  logic [9:0]  bird_h, bird_v;
  logic [79:0] rect_h, rect_v, rect_w, rect_ht;
  logic [1:0]  game_state;
  logic        collide, freeze;
  logic [11:0] score_bcd, hiscore_bcd;

  always #5 clk = ~clk;

  tube_hit_judge #(
    .N_RECT(N), .SCORE_MASK(MASK), .BIRD_W(BW), .BIRD_H(BH), .HIT_FRAMES(HF)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start),
    .bird_h(bird_h), .bird_v(bird_v),
    .rect_h(rect_h), .rect_v(rect_v), .rect_w(rect_w), .rect_ht(rect_ht),
    .game_state(game_state), .collide(collide), .freeze(freeze),
    .score_bcd(score_bcd), .hiscore_bcd(hiscore_bcd)
  );

  int rh[N], rv[N], rw[N], rt[N];
  int bh, bv;
  int m_state, m_score, m_hi, m_hits;
  bit m_hist[N];
  bit m_collide;
  int checks = 0;
  int errors = 0;

  function automatic logic [11:0] to_bcd(int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [27:0] exp_vec();
    logic [11:0] hb;
`ifdef TUBE_HISCORE_EN
    hb = to_bcd(m_hi);
`else
    hb = 12'h000;
`endif
    return {2'(m_state), m_collide, (m_state >= 2), to_bcd(m_score), hb};
  endfunction

  function automatic logic [27:0] out_vec();
    return {game_state, collide, freeze, score_bcd, hiscore_bcd};
  endfunction

  task automatic model_reset();
    m_state = 0; m_score = 0; m_hi = 0; m_hits = 0; m_collide = 0;
    for (int i = 0; i < N; i++) m_hist[i] = 0;
  endtask

  // One frame judged from the game rules with plain integer arithmetic
  task automatic model_tick();
    bit hit;
    bit ahead;
    int passes;
    hit = (bv + BH > 480);
    passes = 0;
    for (int i = 0; i < N; i++) begin
      if (rw[i] > 0 && rt[i] > 0 && bh < rh[i] + rw[i] && rh[i] < bh + BW &&
          bv < rv[i] + rt[i] && rv[i] < bv + BH) hit = 1;
      ahead = (rh[i] + rw[i] > bh);
      if (MASK[i] && m_hist[i] && !ahead) passes++;
      m_hist[i] = ahead;
    end
    m_collide = 0;
    if (m_state == 1) begin
      if (hit) begin
        m_state = 2; m_hits = 0; m_collide = 1;
      end else begin
        m_score = (m_score + passes > 999) ? 999 : m_score + passes;
      end
    end else if (m_state == 2) begin
      m_hits++;
      if (m_hits == HF) begin
        m_state = 3;
        if (m_score > m_hi) m_hi = m_score;
      end
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      rect_h[10*i +: 10]  = 10'(rh[i]);
      rect_v[10*i +: 10]  = 10'(rv[i]);
      rect_w[10*i +: 10]  = 10'(rw[i]);
      rect_ht[10*i +: 10] = 10'(rt[i]);
    end
    bird_h = 10'(bh);
    bird_v = 10'(bv);
  endtask

  task automatic park();
    for (int i = 0; i < N; i++) begin
      rh[i] = 800; rw[i] = 10; rv[i] = 0; rt[i] = 10;
    end
    bh = 100; bv = 200;
  endtask

  // tick at cycle 0, outputs sampled on the negedge after the second posedge
  task automatic do_tick();
    apply();
    model_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (m_state == 0 || m_state == 3) begin
      m_state = 1; m_score = 0;
      for (int i = 0; i < N; i++) m_hist[i] = 0;
    end
    m_collide = 0;
  endtask

  // k masked rectangles (plus all unmasked ones) go from ahead to behind
  task automatic pass_step(int k);
    for (int i = 0; i < N; i++) begin
      rh[i] = 500; rw[i] = 10; rv[i] = 0; rt[i] = 10;
    end
    do_tick();
    for (int j = 0; j < k; j++) rh[2*j] = 0;
    for (int i = 1; i < N; i += 2) rh[i] = 0;
    do_tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b0; start = 1'b0;
    park(); apply();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++;
    if (out_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_state: got %h expected %h", out_vec(), exp_vec());
    end
    rh[4] = 110; rv[4] = 200; rw[4] = 10; rt[4] = 10;
    do_tick();
    checks++;
    if (game_state !== 2'd0 || out_vec() !== exp_vec()) begin
      errors++; $display("FAIL idle_ignores_hit: got %h expected %h", out_vec(), exp_vec());
    end
    park();
  endtask

  task automatic test_pass();
    do_start();
    checks++;
    if (game_state !== 2'd1 || out_vec() !== exp_vec()) begin
      errors++; $display("FAIL start_play: got %h expected %h", out_vec(), exp_vec());
    end
    park();
    rh[0] = 200; rw[0] = 60; rv[0] = 0; rt[0] = 100;
    rh[1] = 200; rw[1] = 60; rv[1] = 0; rt[1] = 100;
    rh[2] = 110; rw[2] = 0;  rv[2] = 205; rt[2] = 50;
    rh[3] = 110; rw[3] = 20; rv[3] = 205; rt[3] = 0;
    for (int h = 200; h >= 30; h--) begin
      rh[0] = h; rh[1] = h;
      do_tick();
      checks++;
      if (out_vec() !== exp_vec()) begin
        errors++; $display("FAIL pass_walk h=%0d: got %h expected %h", h, out_vec(), exp_vec());
      end
    end
    checks++;
    if (score_bcd !== 12'h001) begin
      errors++; $display("FAIL pass_single: got %h expected 001", score_bcd);
    end
    do_start();
    checks++;
    if (game_state !== 2'd1 || score_bcd !== 12'h001) begin
      errors++; $display("FAIL start_in_play: got %h/%h expected 1/001", game_state, score_bcd);
    end
  endtask

  task automatic test_hit_boundary();
    int hpos[5];
    int vpos[5];
    int htv[5];
    hpos = '{134, 80, 110, 110, 133};
    vpos = '{200, 200, 224, 176, 200};
    htv  = '{50, 50, 10, 24, 50};
    park();
    for (int s = 0; s < 5; s++) begin
      rh[4] = hpos[s]; rw[4] = 20; rv[4] = vpos[s]; rt[4] = htv[s];
      do_tick();
      checks++;
      if (game_state !== ((s == 4) ? 2'd2 : 2'd1) || out_vec() !== exp_vec()) begin
        errors++; $display("FAIL edge_step%0d: got %h expected %h", s, out_vec(), exp_vec());
      end
    end
    checks++;
    if (collide !== 1'b1 || freeze !== 1'b1) begin
      errors++; $display("FAIL collide_pulse: got %b/%b expected 1/1", collide, freeze);
    end
    park();
    for (int t = 1; t <= HF; t++) begin
      do_tick();
      checks++;
      if (game_state !== ((t == HF) ? 2'd3 : 2'd2) || freeze !== 1'b1 || out_vec() !== exp_vec()) begin
        errors++; $display("FAIL hit_hold t=%0d: got %h expected %h", t, out_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_floor();
    do_start();
    park();
    bv = 456;
    do_tick();
    checks++;
    if (game_state !== 2'd1 || out_vec() !== exp_vec()) begin
      errors++; $display("FAIL floor_456: got %h expected %h", out_vec(), exp_vec());
    end
    bv = 457;
    do_tick();
    checks++;
    if (game_state !== 2'd2 || collide !== 1'b1 || out_vec() !== exp_vec()) begin
      errors++; $display("FAIL floor_457: got %h expected %h", out_vec(), exp_vec());
    end
    bv = 200;
    for (int t = 1; t <= HF; t++) do_tick();
    checks++;
    if (game_state !== 2'd3 || out_vec() !== exp_vec()) begin
      errors++; $display("FAIL floor_over: got %h expected %h", out_vec(), exp_vec());
    end
  endtask

  task automatic test_hit_and_pass();
    do_start();
    park();
    do_tick();
    rh[0] = 0;
    do_tick();
    rh[0] = 800;
    do_tick();
    rh[0] = 0;
    rh[5] = 110; rv[5] = 200; rw[5] = 10; rt[5] = 10;
    do_tick();
    checks++;
    if (game_state !== 2'd2 || score_bcd !== 12'h001 || out_vec() !== exp_vec()) begin
      errors++; $display("FAIL hit_wins: got %h expected %h", out_vec(), exp_vec());
    end
    park();
    for (int t = 1; t <= HF; t++) do_tick();
  endtask

  task automatic test_saturation();
    do_start();
    park();
    for (int s = 0; s < 249; s++) begin
      pass_step(4);
      checks++;
      if (out_vec() !== exp_vec()) begin
        errors++; $display("FAIL sat_climb s=%0d: got %h expected %h", s, out_vec(), exp_vec());
      end
    end
    pass_step(2);
    checks++;
    if (score_bcd !== 12'h998) begin
      errors++; $display("FAIL sat_998: got %h expected 998", score_bcd);
    end
    pass_step(2);
    checks++;
    if (score_bcd !== 12'h999) begin
      errors++; $display("FAIL sat_999: got %h expected 999", score_bcd);
    end
    pass_step(1);
    checks++;
    if (score_bcd !== 12'h999 || out_vec() !== exp_vec()) begin
      errors++; $display("FAIL sat_hold: got %h expected %h", out_vec(), exp_vec());
    end
    park();
    rh[5] = 110; rv[5] = 200; rw[5] = 10; rt[5] = 10;
    do_tick();
    park();
    for (int t = 1; t <= HF; t++) do_tick();
    checks++;
`ifdef TUBE_HISCORE_EN
    if (game_state !== 2'd3 || hiscore_bcd !== 12'h999) begin
`else
    if (game_state !== 2'd3 || hiscore_bcd !== 12'h000) begin
`endif
      errors++; $display("FAIL hiscore_over: got %h/%h", game_state, hiscore_bcd);
    end
    do_start();
    checks++;
    if (game_state !== 2'd1 || score_bcd !== 12'h000 || out_vec() !== exp_vec()) begin
      errors++; $display("FAIL restart: got %h expected %h", out_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_midgame();
    park();
    for (int s = 0; s < 10; s++) pass_step(4);
    pass_step(2);
    checks++;
    if (game_state !== 2'd1 || score_bcd !== 12'h042) begin
      errors++; $display("FAIL score_42: got %h/%h expected 1/042", game_state, score_bcd);
    end
    park();
    rh[5] = 110; rv[5] = 200; rw[5] = 10; rt[5] = 10;
    apply();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++;
    if (out_vec() !== 28'h0 || out_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_midgame: got %h expected %h", out_vec(), exp_vec());
    end
    @(negedge clk);
    checks++;
    if (out_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_flush: got %h expected %h", out_vec(), exp_vec());
    end
    park();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if ((m_state == 0 || m_state == 3) && $urandom_range(0, 3) == 0) begin
        do_start();
        checks++;
        if (out_vec() !== exp_vec()) begin
          errors++; $display("FAIL rand_start n=%0d: got %h expected %h", n, out_vec(), exp_vec());
        end
      end
      bh = int'($urandom_range(0, 815));
      bv = int'($urandom_range(0, 460));
      for (int i = 0; i < N; i++) begin
        rh[i] = int'($urandom_range(0, 849));
        rw[i] = int'($urandom_range(0, 40));
        rv[i] = int'($urandom_range(0, 479));
        rt[i] = int'($urandom_range(0, 60));
      end
      do_tick();
      checks++;
      if (out_vec() !== exp_vec()) begin
        errors++; $display("FAIL rand_tick n=%0d: got %h expected %h", n, out_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0;
    park(); apply();
    @(negedge clk);
    test_reset();
    test_pass();
    test_hit_boundary();
    test_floor();
    test_hit_and_pass();
    test_saturation();
    test_reset_midgame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
